// File: rtl/hwpe_stream_tcdm_responder.sv
// hwpe_stream_tcdm_responder: NB_CHAN independent TCDM slave channels (in: clk_i rst_i clear_i in_req in_add in_wen in_be in_data; out: in_gnt in_r_valid in_r_data), each a private word memory with LATENCY-cycle responses, optional grant stalls under HWPE_TCDM_RESPONDER_STALL_EN
module hwpe_stream_tcdm_responder #(
  parameter int NB_CHAN   = 2,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [NB_CHAN-1:0]      in_req,
  input  logic [NB_CHAN-1:0][31:0] in_add,
  input  logic [NB_CHAN-1:0]      in_wen,
  input  logic [NB_CHAN-1:0][3:0] in_be,
  input  logic [NB_CHAN-1:0][31:0] in_data,
  output logic [NB_CHAN-1:0]      in_gnt,
  output logic [NB_CHAN-1:0]      in_r_valid,
  output logic [NB_CHAN-1:0][31:0] in_r_data
);
  localparam int AW = $clog2(MEM_WORDS);
  for (genvar c = 0; c < NB_CHAN; c++) begin : g_ch
    logic [31:0] mem_q [MEM_WORDS];
    logic        vld_q [LATENCY];
    logic        vld_d [LATENCY];
    logic [31:0] dat_q [LATENCY];
    logic [31:0] dat_d [LATENCY];
    logic [AW-1:0] idx;
    logic [31:0] wmask, wr_word;
    logic stall, xfer, unused_add;
    assign unused_add = ^{in_add[c][31:AW+2], in_add[c][1:0]};
`ifdef HWPE_TCDM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = clear_i ? (16'hACE1 ^ 16'(c)) : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) lfsr_q <= 16'hACE1 ^ 16'(c);
      else lfsr_q <= lfsr_d;
    always_comb stall = ~rst_i & (lfsr_q[1:0] == 2'b00);
`else
    always_comb stall = 1'b0;
`endif
    always_comb begin
      idx = in_add[c][2 +: AW];
      wmask = {{8{in_be[c][3]}}, {8{in_be[c][2]}}, {8{in_be[c][1]}}, {8{in_be[c][0]}}};
      wr_word = (mem_q[idx] & ~wmask) | (in_data[c] & wmask);
      xfer = in_req[c] & ~clear_i & ~stall;
      vld_d[0] = xfer;
      dat_d[0] = (xfer & in_wen[c]) ? mem_q[idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
    assign in_gnt[c]     = xfer;
    assign in_r_valid[c] = vld_q[LATENCY-1];
    assign in_r_data[c]  = dat_q[LATENCY-1];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          vld_q[i] <= 1'b0;
          dat_q[i] <= '0;
        end
      end else begin
        if (xfer & ~in_wen[c]) mem_q[idx] <= wr_word;
        for (int i = 0; i < LATENCY; i++) begin
          vld_q[i] <= vld_d[i] & ~clear_i;
          dat_q[i] <= clear_i ? 32'h0 : dat_d[i];
        end
      end
    end
  end
endmodule
